// File: rtl/scr1_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// scr1_dmem_arbiter
//
// Shares the data-memory router's core-side port between the SCR1 core and
// the RLWE accelerator. Only one transaction is outstanding at a time. The
// core has priority, but after RLWE_MAX_WAIT consecutive core grants with an
// RLWE request waiting, the RLWE engine is granted once. The grant is held
// through a stalled address phase, and the response goes only to the
// requester that owns the transaction.
//
// The package at the top of this file carries the SCR1 memory-interface
// types and encodings, so the block is self-contained.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   core_dmem_*         core data port (req/cmd/width/addr/wdata in,
//                       req_ack/rdata/resp out)
//   rlwe_dmem_*         RLWE data port, same signals and directions as core
//   dmem_*              single master port towards the router
//                       (req/cmd/width/addr/wdata out,
//                       req_ack/rdata/resp in)
//   arb_owner           owner of current/last transaction (0 core, 1 RLWE)
//   arb_busy            transaction outstanding (FSM in DATA)
// ---------------------------------------------------------------------------

package scr1_dmem_arb_pkg;
  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef logic [SCR1_DMEM_DWIDTH-1:0] type_vector;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_arbiter
  import scr1_dmem_arb_pkg::*;
#(
  parameter int RLWE_MAX_WAIT = 4,
  parameter int CNT_W         = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        core_dmem_req,
  input  type_scr1_mem_cmd_e          core_dmem_cmd,
  input  type_scr1_mem_width_e        core_dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] core_dmem_addr,
  input  type_vector                  core_dmem_wdata,
  output logic                        core_dmem_req_ack,
  output type_vector                  core_dmem_rdata,
  output type_scr1_mem_resp_e         core_dmem_resp,

  input  logic                        rlwe_dmem_req,
  input  type_scr1_mem_cmd_e          rlwe_dmem_cmd,
  input  type_scr1_mem_width_e        rlwe_dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] rlwe_dmem_addr,
  input  type_vector                  rlwe_dmem_wdata,
  output logic                        rlwe_dmem_req_ack,
  output type_vector                  rlwe_dmem_rdata,
  output type_scr1_mem_resp_e         rlwe_dmem_resp,

  output logic                        dmem_req,
  output type_scr1_mem_cmd_e          dmem_cmd,
  output type_scr1_mem_width_e        dmem_width,
  output logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  output type_vector                  dmem_wdata,
  input  logic                        dmem_req_ack,
  input  type_vector                  dmem_rdata,
  input  type_scr1_mem_resp_e         dmem_resp,

  output logic                        arb_owner,
  output logic                        arb_busy
);

  typedef enum logic {
    ST_ADDR = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] MAX_WAIT = CNT_W'(RLWE_MAX_WAIT);
  localparam bit               GUARD_EN = (RLWE_MAX_WAIT != 0);

  state_e           fsm;
  logic             owner_r;
  logic             lock_v;
  logic             lock_sel;
  logic [CNT_W-1:0] starve_cnt;

  logic             arb_en;
  logic             guard_hit;
  logic             sel_rlwe;
  logic             accept;

  // Arbitration is open in ADDR, and in DATA only on the RDY_OK cycle so a
  // new request can be issued back-to-back with the completing one.
  always_comb begin
    arb_en    = (fsm == ST_ADDR) || (dmem_resp == SCR1_MEM_RESP_RDY_OK);
    guard_hit = GUARD_EN && (starve_cnt == MAX_WAIT) &&
                core_dmem_req && rlwe_dmem_req;
    // A stalled address phase keeps its requester even if the other side
    // would now win, so the router never sees the request change under it.
    if (lock_v)             sel_rlwe = lock_sel;
    else if (guard_hit)     sel_rlwe = 1'b1;
    else if (core_dmem_req) sel_rlwe = 1'b0;
    else if (rlwe_dmem_req) sel_rlwe = 1'b1;
    else                    sel_rlwe = 1'b0;
  end

  assign dmem_req   = arb_en & (sel_rlwe ? rlwe_dmem_req : core_dmem_req);
  assign dmem_cmd   = sel_rlwe ? rlwe_dmem_cmd   : core_dmem_cmd;
  assign dmem_width = sel_rlwe ? rlwe_dmem_width : core_dmem_width;
  assign dmem_addr  = sel_rlwe ? rlwe_dmem_addr  : core_dmem_addr;
  assign dmem_wdata = sel_rlwe ? rlwe_dmem_wdata : core_dmem_wdata;

  assign accept = dmem_req & dmem_req_ack;

  // The router's ack is only forwarded while a request is actually driven,
  // and never to the requester that is not selected.
  assign core_dmem_req_ack = dmem_req & ~sel_rlwe & dmem_req_ack;
  assign rlwe_dmem_req_ack = dmem_req &  sel_rlwe & dmem_req_ack;

  always_comb begin
    core_dmem_rdata = '0;
    core_dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    rlwe_dmem_rdata = '0;
    rlwe_dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    if (fsm == ST_DATA) begin
      if (owner_r) begin
        rlwe_dmem_rdata = dmem_rdata;
        rlwe_dmem_resp  = dmem_resp;
      end else begin
        core_dmem_rdata = dmem_rdata;
        core_dmem_resp  = dmem_resp;
      end
    end
  end

  assign arb_owner = owner_r;
  assign arb_busy  = (fsm == ST_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= ST_ADDR;
      owner_r    <= 1'b0;
      lock_v     <= 1'b0;
      lock_sel   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (fsm)
        ST_ADDR: begin
          if (accept) begin
            fsm     <= ST_DATA;
            owner_r <= sel_rlwe;
          end
        end
        ST_DATA: begin
          case (dmem_resp)
            SCR1_MEM_RESP_RDY_OK: begin
              if (accept) owner_r <= sel_rlwe;
              else        fsm     <= ST_ADDR;
            end
            SCR1_MEM_RESP_RDY_ER: fsm <= ST_ADDR;
            default: ;
          endcase
        end
        default: fsm <= ST_ADDR;
      endcase

      // Lock is re-evaluated every arbitration cycle: it is set by a stalled
      // request and drops on accept or when the locked requester withdraws.
      if (arb_en) begin
        lock_v <= dmem_req & ~dmem_req_ack;
        if (dmem_req & ~dmem_req_ack) lock_sel <= sel_rlwe;
      end

      if (!rlwe_dmem_req || (accept && sel_rlwe))
        starve_cnt <= '0;
      else if (accept && !sel_rlwe && (starve_cnt != MAX_WAIT))
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_scr1_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_scr1_dmem_arbiter
//
// Directed bench for scr1_dmem_arbiter. The stimulus process plays the core,
// the RLWE engine and the router cycle by cycle and queues every address
// accept and response it expects. A monitor on the falling edge pops that
// queue whenever either requester sees req_ack or a non-NOTRDY response.
// A few cycle-exact properties are also checked inline.
// ---------------------------------------------------------------------------

module tb_scr1_dmem_arbiter;
  import scr1_dmem_arb_pkg::*;

  logic                 clk;
  logic                 rst_n;

  logic                 core_dmem_req;
  type_scr1_mem_cmd_e   core_dmem_cmd;
  type_scr1_mem_width_e core_dmem_width;
  logic [31:0]          core_dmem_addr;
  type_vector           core_dmem_wdata;
  logic                 core_dmem_req_ack;
  type_vector           core_dmem_rdata;
  type_scr1_mem_resp_e  core_dmem_resp;

  logic                 rlwe_dmem_req;
  type_scr1_mem_cmd_e   rlwe_dmem_cmd;
  type_scr1_mem_width_e rlwe_dmem_width;
  logic [31:0]          rlwe_dmem_addr;
  type_vector           rlwe_dmem_wdata;
  logic                 rlwe_dmem_req_ack;
  type_vector           rlwe_dmem_rdata;
  type_scr1_mem_resp_e  rlwe_dmem_resp;

  logic                 dmem_req;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr;
  type_vector           dmem_wdata;
  logic                 dmem_req_ack;
  type_vector           dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;

  logic                 arb_owner;
  logic                 arb_busy;

  scr1_dmem_arbiter #(.RLWE_MAX_WAIT(4), .CNT_W(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .core_dmem_req     (core_dmem_req),
    .core_dmem_cmd     (core_dmem_cmd),
    .core_dmem_width   (core_dmem_width),
    .core_dmem_addr    (core_dmem_addr),
    .core_dmem_wdata   (core_dmem_wdata),
    .core_dmem_req_ack (core_dmem_req_ack),
    .core_dmem_rdata   (core_dmem_rdata),
    .core_dmem_resp    (core_dmem_resp),
    .rlwe_dmem_req     (rlwe_dmem_req),
    .rlwe_dmem_cmd     (rlwe_dmem_cmd),
    .rlwe_dmem_width   (rlwe_dmem_width),
    .rlwe_dmem_addr    (rlwe_dmem_addr),
    .rlwe_dmem_wdata   (rlwe_dmem_wdata),
    .rlwe_dmem_req_ack (rlwe_dmem_req_ack),
    .rlwe_dmem_rdata   (rlwe_dmem_rdata),
    .rlwe_dmem_resp    (rlwe_dmem_resp),
    .dmem_req          (dmem_req),
    .dmem_cmd          (dmem_cmd),
    .dmem_width        (dmem_width),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_req_ack      (dmem_req_ack),
    .dmem_rdata        (dmem_rdata),
    .dmem_resp         (dmem_resp),
    .arb_owner         (arb_owner),
    .arb_busy          (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        who;      // 0 core, 1 RLWE
    logic        is_resp;  // 0 address accept, 1 response
    logic [31:0] val;      // dmem_addr for accepts, rdata for responses
    logic [1:0]  resp;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic exp_acc(input logic who, input logic [31:0] a);
    exp_q.push_back('{who: who, is_resp: 1'b0, val: a, resp: 2'b00});
  endtask

  task automatic exp_rsp(input logic who, input logic [31:0] d, input logic [1:0] r);
    exp_q.push_back('{who: who, is_resp: 1'b1, val: d, resp: r});
  endtask

  task automatic got(input logic who, input logic is_resp, input logic [31:0] val,
                     input logic [1:0] r);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got who=%0d resp_ev=%0d val=%h resp=%0d want none",
               who, is_resp, val, r);
    end else begin
      e = exp_q.pop_front();
      if (e.who !== who || e.is_resp !== is_resp || e.val !== val || e.resp !== r) begin
        bad++;
        $display("FAIL event_t%0t: got who=%0d resp_ev=%0d val=%h resp=%0d want who=%0d resp_ev=%0d val=%h resp=%0d",
                 $time, who, is_resp, val, r, e.who, e.is_resp, e.val, e.resp);
      end
    end
  endtask

  // Responses are checked before accepts in the same cycle; the stimulus
  // queues them in that order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_dmem_resp != SCR1_MEM_RESP_NOTRDY) got(1'b0, 1'b1, core_dmem_rdata, core_dmem_resp);
      if (rlwe_dmem_resp != SCR1_MEM_RESP_NOTRDY) got(1'b1, 1'b1, rlwe_dmem_rdata, rlwe_dmem_resp);
      if (core_dmem_req_ack) got(1'b0, 1'b0, dmem_addr, 2'b00);
      if (rlwe_dmem_req_ack) got(1'b1, 1'b0, dmem_addr, 2'b00);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_dmem_req   = 1'b0;
    core_dmem_cmd   = SCR1_MEM_CMD_RD;
    core_dmem_width = SCR1_MEM_WIDTH_WORD;
    core_dmem_addr  = '0;
    core_dmem_wdata = '0;
    rlwe_dmem_req   = 1'b0;
    rlwe_dmem_cmd   = SCR1_MEM_CMD_RD;
    rlwe_dmem_width = SCR1_MEM_WIDTH_WORD;
    rlwe_dmem_addr  = '0;
    rlwe_dmem_wdata = '0;
    dmem_req_ack    = 1'b0;
    dmem_rdata      = '0;
    dmem_resp       = SCR1_MEM_RESP_NOTRDY;
  endtask

  logic [9:0] gseq;

  initial begin
    rst_n = 1'b0;
    idle();
    // Router noise during reset must not reach either requester.
    dmem_resp  = SCR1_MEM_RESP_RDY_OK;
    dmem_rdata = 32'hFFFF_FFFF;
    dmem_req_ack = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_dmem_req",  dmem_req, 0);
    chk("rst_core_ack",  core_dmem_req_ack, 0);
    chk("rst_rlwe_ack",  rlwe_dmem_req_ack, 0);
    chk("rst_core_resp", core_dmem_resp, SCR1_MEM_RESP_NOTRDY);
    chk("rst_rlwe_resp", rlwe_dmem_resp, SCR1_MEM_RESP_NOTRDY);
    chk("rst_core_rdata", core_dmem_rdata, 0);
    chk("rst_rlwe_rdata", rlwe_dmem_rdata, 0);
    chk("rst_owner", arb_owner, 0);
    chk("rst_busy",  arb_busy, 0);
    cyc();
    rst_n = 1'b1;
    idle();

    // 1: core-only read, two wait states
    core_dmem_req = 1'b1; core_dmem_addr = 32'h0001_0000; dmem_req_ack = 1'b1;
    exp_acc(1'b0, 32'h0001_0000);
    #2 chk("t1_core_ack_c0", core_dmem_req_ack, 1);
    chk("t1_rlwe_ack_c0", rlwe_dmem_req_ack, 0);
    cyc();
    core_dmem_req = 1'b0; dmem_req_ack = 1'b0; dmem_rdata = 32'h1234_5678;
    #2 chk("t1_core_notrdy1", core_dmem_resp, SCR1_MEM_RESP_NOTRDY);
    chk("t1_busy", arb_busy, 1);
    chk("t1_core_rdata_pass", core_dmem_rdata, 32'h1234_5678);
    chk("t1_rlwe_rdata_zero", rlwe_dmem_rdata, 0);
    cyc();
    #2 chk("t1_core_notrdy2", core_dmem_resp, SCR1_MEM_RESP_NOTRDY);
    cyc();
    dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 32'hCAFE_0001;
    exp_rsp(1'b0, 32'hCAFE_0001, SCR1_MEM_RESP_RDY_OK);
    #2 chk("t1_rlwe_resp", rlwe_dmem_resp, SCR1_MEM_RESP_NOTRDY);
    chk("t1_owner", arb_owner, 0);
    cyc();

    // 2: continuous contention, single-cycle responses; R at grants 4 and 9
    gseq = 10'b10_0001_0000;
    for (int k = 0; k < 10; k++) begin
      core_dmem_req = 1'b1; core_dmem_addr = 32'h0000_0100 + 32'(4 * k);
      rlwe_dmem_req = 1'b1; rlwe_dmem_addr = 32'h0000_0800 + 32'(4 * k);
      dmem_req_ack  = 1'b1;
      dmem_resp     = (k == 0) ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK;
      dmem_rdata    = 32'h0000_D000 + 32'(k);
      if (k > 0) exp_rsp(gseq[k-1], 32'h0000_D000 + 32'(k), SCR1_MEM_RESP_RDY_OK);
      exp_acc(gseq[k], gseq[k] ? rlwe_dmem_addr : core_dmem_addr);
      cyc();
    end
    core_dmem_req = 1'b0; rlwe_dmem_req = 1'b0; dmem_req_ack = 1'b0;
    dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 32'h0000_D00A;
    exp_rsp(gseq[9], 32'h0000_D00A, SCR1_MEM_RESP_RDY_OK);
    cyc();

    // 3: stalled RLWE accept, core arrives during the stall
    idle();
    rlwe_dmem_req = 1'b1; rlwe_dmem_addr = 32'h0000_0A00;
    rlwe_dmem_cmd = SCR1_MEM_CMD_WR; rlwe_dmem_wdata = 32'h0BAD_F00D;
    #2 chk("t3_addr_c0", dmem_addr, 32'h0000_0A00);
    chk("t3_req_c0", dmem_req, 1);
    cyc();
    for (int k = 1; k < 3; k++) begin
      core_dmem_req = 1'b1; core_dmem_addr = 32'h0000_0C00;
      #2 chk("t3_addr_stall", dmem_addr, 32'h0000_0A00);
      chk("t3_core_ack_stall", core_dmem_req_ack, 0);
      cyc();
    end
    dmem_req_ack = 1'b1;
    exp_acc(1'b1, 32'h0000_0A00);
    #2 chk("t3_core_ack_acc", core_dmem_req_ack, 0);
    chk("t3_wdata", dmem_wdata, 32'h0BAD_F00D);
    cyc();
    core_dmem_req = 1'b0; rlwe_dmem_req = 1'b0; dmem_req_ack = 1'b0;
    dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 32'h0000_A5A5;
    exp_rsp(1'b1, 32'h0000_A5A5, SCR1_MEM_RESP_RDY_OK);
    #2 chk("t3_owner", arb_owner, 1);
    cyc();

    // 4: three back-to-back core writes
    idle();
    core_dmem_req = 1'b1; core_dmem_cmd = SCR1_MEM_CMD_WR;
    core_dmem_addr = 32'h0000_3000; dmem_req_ack = 1'b1;
    exp_acc(1'b0, 32'h0000_3000);
    #2 chk("t4_cmd", dmem_cmd, SCR1_MEM_CMD_WR);
    cyc();
    for (int k = 1; k < 3; k++) begin
      core_dmem_addr = 32'h0000_3000 + 32'(4 * k);
      dmem_resp = SCR1_MEM_RESP_RDY_OK;
      exp_rsp(1'b0, 32'h0, SCR1_MEM_RESP_RDY_OK);
      exp_acc(1'b0, core_dmem_addr);
      #2 chk("t4_ack_b2b", core_dmem_req_ack, 1);
      chk("t4_busy", arb_busy, 1);
      cyc();
    end
    core_dmem_req = 1'b0; dmem_req_ack = 1'b0;
    exp_rsp(1'b0, 32'h0, SCR1_MEM_RESP_RDY_OK);
    #2 chk("t4_busy_last", arb_busy, 1);
    cyc();

    // 5: error response while core keeps requesting
    idle();
    core_dmem_req = 1'b1; core_dmem_addr = 32'h0000_4000; dmem_req_ack = 1'b1;
    exp_acc(1'b0, 32'h0000_4000);
    cyc();
    core_dmem_addr = 32'h0000_4004;
    dmem_resp = SCR1_MEM_RESP_RDY_ER; dmem_rdata = 32'h0000_00EE;
    exp_rsp(1'b0, 32'h0000_00EE, SCR1_MEM_RESP_RDY_ER);
    #2 chk("t5_req_on_err", dmem_req, 0);
    chk("t5_ack_on_err", core_dmem_req_ack, 0);
    cyc();
    dmem_resp = SCR1_MEM_RESP_NOTRDY; dmem_rdata = '0;
    exp_acc(1'b0, 32'h0000_4004);
    #2 chk("t5_req_after", dmem_req, 1);
    chk("t5_busy_after", arb_busy, 0);
    cyc();
    core_dmem_req = 1'b0; dmem_req_ack = 1'b0;
    dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 32'h0000_0077;
    exp_rsp(1'b0, 32'h0000_0077, SCR1_MEM_RESP_RDY_OK);
    cyc();

    // 6: build starvation count to the limit, then reset mid-transaction
    idle();
    core_dmem_req = 1'b1; core_dmem_addr = 32'h0000_5000;
    rlwe_dmem_req = 1'b1; rlwe_dmem_addr = 32'h0000_5800;
    dmem_req_ack = 1'b1;
    exp_acc(1'b0, 32'h0000_5000);
    cyc();
    for (int k = 1; k < 4; k++) begin
      core_dmem_addr = 32'h0000_5000 + 32'(4 * k);
      dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 32'h0000_0600 + 32'(k);
      exp_rsp(1'b0, dmem_rdata, SCR1_MEM_RESP_RDY_OK);
      exp_acc(1'b0, core_dmem_addr);
      cyc();
    end
    dmem_resp = SCR1_MEM_RESP_NOTRDY; dmem_rdata = 32'hBAD0_BAD0;
    #2 chk("t6_rdata_pre", core_dmem_rdata, 32'hBAD0_BAD0);
    chk("t6_busy_pre", arb_busy, 1);
    core_dmem_req = 1'b0; rlwe_dmem_req = 1'b0;
    rst_n = 1'b0;
    #1 chk("t6_busy_rst", arb_busy, 0);
    chk("t6_rdata_rst", core_dmem_rdata, 0);
    chk("t6_resp_rst", core_dmem_resp, SCR1_MEM_RESP_NOTRDY);
    chk("t6_req_rst", dmem_req, 0);
    chk("t6_ack_rst", core_dmem_req_ack, 0);
    chk("t6_owner_rst", arb_owner, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    idle();
    core_dmem_req = 1'b1; core_dmem_addr = 32'h0000_5100;
    rlwe_dmem_req = 1'b1; rlwe_dmem_addr = 32'h0000_5900;
    dmem_req_ack = 1'b1;
    exp_acc(1'b0, 32'h0000_5100);
    cyc();
    core_dmem_req = 1'b0; rlwe_dmem_req = 1'b0; dmem_req_ack = 1'b0;
    dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 32'h0000_0099;
    exp_rsp(1'b0, 32'h0000_0099, SCR1_MEM_RESP_RDY_OK);
    cyc();
    idle();
    cyc();
    cyc();

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
